ex_muldiv: RTL
==============

// Module: ex_muldiv
// PURPOSE
//  Multi-cycle RV32M execute unit sitting beside the combinational EX ALU.
//  It handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (opcode OP, funct7=0000001).
//  Operands are latched on acceptance. It stalls the pipeline through the EX stallreq path
//  until the result is ready, then presents the result for exactly one cycle.
// PARAMETERS
//  XLEN            32  operand/result width; must be even, >=8
//  MUL_BITS_PER_CYC 32 multiplier bits retired per cycle; must divide XLEN (XLEN => 1 iteration)
// PORTS
//  clk         in   1     clock
//  rst         in   1     reset; synchronous, active-high
//  start_i     in   1     EX holds an M-extension op this cycle
//  funct3_i    in   3     M op select (MUL=000 .. REMU=111)
//  op1_i       in   XLEN  rs1 value
//  op2_i       in   XLEN  rs2 value
//  wd_i        in   5     destination register
//  flush_i     in   1     cancel any in-flight op (branch/jump redirect)
//  stallreq_o  out  1     to stall controller: hold IF/ID/EX
//  busy_o      out  1     state != IDLE
//  done_o      out  1     result_o/wd_o valid this cycle; wreg asserted downstream
//  result_o    out  XLEN  result
//  wd_o        out  5     latched destination register
// BEHAVIOUR
//  - Reset: state=IDLE; stallreq_o, busy_o, done_o = 0; result_o = 0; wd_o = 0.
//  - States: IDLE, MUL, DIV, DONE.
//  - IDLE: start_i & !flush_i at a clock edge (cycle 0) latches op1, op2, funct3, wd.
//    * funct3[2]=0 -> MUL.
//    * Division with op2==0, or signed overflow (op1=min, op2=-1) -> DONE directly.
//    * Other divisions -> DIV.
//  - MUL: NM = XLEN/MUL_BITS_PER_CYC iterations of shift-add on a 2*XLEN product.
//    * Operands are sign-extended per funct3: MULH s*s, MULHSU s*u, MULHU/MUL u*u.
//    * MUL returns the low XLEN bits; MULH* return the high XLEN bits.
//  - DIV: XLEN iterations of restoring radix-2 division on magnitudes.
//    * Quotient is negated if the operand signs differ (signed ops only).
//    * Remainder takes the sign of the dividend.
//  - Special cases:
//    * x/0: quotient = all ones; remainder = op1.
//    * Overflow: quotient = op1; remainder = 0.
//  - Latency: done_o is asserted in cycle NM+1 (MUL), XLEN+1 (DIV) or 1 (special case).
//    * DONE lasts exactly 1 cycle, then returns to IDLE.
//    * A new start_i is accepted in the cycle after DONE, at the earliest.
//  - stallreq_o = (IDLE & start_i & !flush_i) | MUL | DIV. It is combinational and
//    low in DONE, so the pipeline advances in the same cycle the result is presented.
//  - start_i is ignored while busy. Operands may change after acceptance without effect.
//  - flush_i in any state: IDLE next cycle, no done_o, stallreq_o low from the next cycle.
//    flush_i in DONE does not suppress done_o, because the op has already retired.
//  - rst mid-operation: same as flush, and all outputs are zeroed.
//  - result_o and wd_o hold their last value outside DONE; consumers must qualify them
//    with done_o.
// STRUCTURE
//  - defines.v holds:
//    * `FUNCT7_MULDIV (0000001).
//    * `FUNCT3_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//    * State encodings `MD_IDLE/`MD_MUL/`MD_DIV/`MD_DONE.
//  - One sub-module, div_iter: the divider datapath (remainder/quotient registers,
//    iteration counter, one-bit-per-cycle step).
//  - The multiplier, sign fix-up and FSM stay in ex_muldiv.
// TESTING  (XLEN=32, MUL_BITS_PER_CYC=32 unless noted)
//  1. MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, done_o at cycle 2; stallreq_o high in
//     cycles 0-1, low in cycle 2.
//  2. High-half multiplies:
//     * MULH 0x80000000*0x80000000 -> 0x40000000.
//     * MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//     * MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//     * Repeat with MUL_BITS_PER_CYC=4: done_o at cycle 9.
//  3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; DIVU 100/7 -> 14 and
//     REMU -> 2; done_o at cycle 33.
//  4. Division by zero and overflow, all with done_o at cycle 1:
//     * DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
//     * DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5. Abort paths:
//     * flush_i at cycle 10 of a DIV -> no done_o, busy_o=0 at cycle 11, new MUL
//       accepted at cycle 11.
//     * rst at cycle 5 -> all outputs 0 next cycle.
//  6. start_i held high through a DIV -> exactly one done_o; a second start_i in the
//     DONE cycle is ignored, and the same op held into the next cycle is accepted at
//     cycle 34.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide execute unit.
package ex_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Restoring radix-2 divider datapath on unsigned magnitudes, one quotient bit per step.
// The next-step quotient/remainder are exported combinationally so the owner can
// capture the final result on the same edge as the last step.
module ex_muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quot_next,
  output logic [XLEN-1:0] rem_next
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] quot_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] divisor_reg;
  logic [CW-1:0]   cnt_reg;
  logic [XLEN:0]   shifted;
  logic            fits;

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  // When it fits the true difference is below the divisor, so the low XLEN bits suffice.
  always_comb begin
    shifted   = {rem_reg, quot_reg[XLEN-1]};
    fits      = (shifted >= {1'b0, divisor_reg});
    rem_next  = fits ? (shifted[XLEN-1:0] - divisor_reg) : shifted[XLEN-1:0];
    quot_next = {quot_reg[XLEN-2:0], fits};
    last      = (cnt_reg == CW'(XLEN - 1));
  end

  // Quotient register doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_reg    <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      cnt_reg     <= '0;
    end else if (load) begin
      quot_reg    <= dividend;
      rem_reg     <= '0;
      divisor_reg <= divisor;
      cnt_reg     <= '0;
    end else if (step) begin
      quot_reg <= quot_next;
      rem_reg  <= rem_next;
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: shift-add multiplier, restoring divider, control FSM.
// Stalls the pipeline while working and presents the result for one cycle in DONE.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int MUL_BITS_PER_CYC = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      wd_i,
  input  logic            flush_i,
  output logic            stallreq_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wd_o
);

  localparam int NM  = XLEN / MUL_BITS_PER_CYC;
  localparam int MCW = (NM > 1) ? $clog2(NM) : 1;

  md_state_e         state_reg;
  logic [XLEN-1:0]   result_reg;
  logic [4:0]        wd_reg;
  logic [4:0]        wd_pend_reg;
  logic              done_reg;
  logic              mul_low_reg;
  logic              rem_sel_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;
  logic [2*XLEN-1:0] mcand_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [MCW-1:0]    mul_cnt_reg;

  logic              accept;
  logic              is_div;
  logic              div_signed;
  logic              a_signed;
  logic              b_signed;
  logic              op1_neg;
  logic              op2_neg;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   op1_mag;
  logic [XLEN-1:0]   op2_mag;
  logic [XLEN-1:0]   special_result;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] acc_init;
  logic [2*XLEN-1:0] partial;
  logic [2*XLEN-1:0] acc_next;
  logic              mul_last;
  logic [XLEN-1:0]   mul_result;
  logic [XLEN-1:0]   div_result;
  logic              div_load;
  logic              div_step;
  logic              div_last;
  logic [XLEN-1:0]   quot_next;
  logic [XLEN-1:0]   rem_next;
  logic [2*XLEN-1:0] pp [MUL_BITS_PER_CYC];

  assign accept     = (state_reg == MD_IDLE) & start_i & ~flush_i;
  assign stallreq_o = accept | (state_reg == MD_MUL) | (state_reg == MD_DIV);
  assign busy_o     = (state_reg != MD_IDLE);
  assign done_o     = done_reg;
  assign result_o   = result_reg;
  assign wd_o       = wd_reg;
  assign div_load   = accept & is_div;
  assign div_step   = (state_reg == MD_DIV);

  // Decode the incoming op: operand signedness, divider magnitudes and the two
  // division corner cases that finish without iterating.
  always_comb begin
    is_div     = funct3_i[2];
    div_signed = ~funct3_i[0];
    a_signed   = (funct3_i == FUNCT3_MULH) || (funct3_i == FUNCT3_MULHSU);
    b_signed   = (funct3_i == FUNCT3_MULH);
    a_ext      = {{XLEN{a_signed & op1_i[XLEN-1]}}, op1_i};
    // A negative signed multiplier has weight -2^XLEN on its top bit; folding that
    // correction into the accumulator start lets the iterations treat it as unsigned.
    acc_init   = (b_signed && op2_i[XLEN-1]) ? -{op1_i, {XLEN{1'b0}}} : '0;
    op1_neg    = div_signed & op1_i[XLEN-1];
    op2_neg    = div_signed & op2_i[XLEN-1];
    op1_mag    = op1_neg ? -op1_i : op1_i;
    op2_mag    = op2_neg ? -op2_i : op2_i;
    div_zero   = (op2_i == '0);
    div_ovf    = div_signed && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    if (div_zero) begin
      special_result = funct3_i[1] ? op1_i : '1;
    end else begin
      special_result = funct3_i[1] ? '0 : op1_i;
    end
  end

  // Partial products for the multiplier bits retired this cycle.
  genvar gi;
  for (gi = 0; gi < MUL_BITS_PER_CYC; gi++) begin : g_pp
    assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
  end

  // Accumulate this cycle's partial products and form both candidate results.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS_PER_CYC; j++) begin
      partial = partial + pp[j];
    end
    acc_next   = acc_reg + partial;
    mul_last   = (mul_cnt_reg == MCW'(NM - 1));
    mul_result = mul_low_reg ? acc_next[XLEN-1:0] : acc_next[2*XLEN-1:XLEN];
    if (rem_sel_reg) begin
      div_result = neg_r_reg ? -rem_next : rem_next;
    end else begin
      div_result = neg_q_reg ? -quot_next : quot_next;
    end
  end

  ex_muldiv_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (op1_mag),
    .divisor  (op2_mag),
    .last     (div_last),
    .quot_next(quot_next),
    .rem_next (rem_next)
  );

  // Control FSM with registered done/result/wd; flush abandons an op unless it is already in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= MD_IDLE;
      result_reg  <= '0;
      wd_reg      <= '0;
      wd_pend_reg <= '0;
      done_reg    <= 1'b0;
      mul_low_reg <= 1'b0;
      rem_sel_reg <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      mplier_reg  <= '0;
      mul_cnt_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          if (accept) begin
            wd_pend_reg <= wd_i;
            if (!is_div) begin
              mcand_reg   <= a_ext;
              mplier_reg  <= op2_i;
              acc_reg     <= acc_init;
              mul_cnt_reg <= '0;
              mul_low_reg <= (funct3_i == FUNCT3_MUL);
              state_reg   <= MD_MUL;
            end else if (div_zero || div_ovf) begin
              result_reg <= special_result;
              wd_reg     <= wd_i;
              done_reg   <= 1'b1;
              state_reg  <= MD_DONE;
            end else begin
              rem_sel_reg <= funct3_i[1];
              neg_q_reg   <= op1_neg ^ op2_neg;
              neg_r_reg   <= op1_neg;
              state_reg   <= MD_DIV;
            end
          end
        end
        MD_MUL: begin
          acc_reg     <= acc_next;
          mcand_reg   <= mcand_reg << MUL_BITS_PER_CYC;
          mplier_reg  <= mplier_reg >> MUL_BITS_PER_CYC;
          mul_cnt_reg <= mul_cnt_reg + 1'b1;
          if (flush_i) begin
            state_reg <= MD_IDLE;
          end else if (mul_last) begin
            result_reg <= mul_result;
            wd_reg     <= wd_pend_reg;
            done_reg   <= 1'b1;
            state_reg  <= MD_DONE;
          end
        end
        MD_DIV: begin
          if (flush_i) begin
            state_reg <= MD_IDLE;
          end else if (div_last) begin
            result_reg <= div_result;
            wd_reg     <= wd_pend_reg;
            done_reg   <= 1'b1;
            state_reg  <= MD_DONE;
          end
        end
        default: begin
          state_reg <= MD_IDLE;
        end
      endcase
    end
  end

endmodule
